// File: rtl/mips_defs.sv
// Shared opcode/funct encodings, class bit positions and pipeline timing constants
// for the decode/hazard pipeline.
package mips_defs;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_CMCO    = 6'b111011;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_LB      = 6'b100000;
    localparam logic [5:0] OP_SB      = 6'b101000;

    localparam logic [5:0] FN_ADDU    = 6'b100001;
    localparam logic [5:0] FN_SUBU    = 6'b100011;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_SLT     = 6'b101010;
    localparam logic [5:0] FN_SLL     = 6'b000000;

    // Bit positions inside the one-hot class vector {JUMP, BRANCH, STORE, LOAD, ALU_I, ALU_R}
    localparam int CLS_ALU_R  = 0;
    localparam int CLS_ALU_I  = 1;
    localparam int CLS_LOAD   = 2;
    localparam int CLS_STORE  = 3;
    localparam int CLS_BRANCH = 4;
    localparam int CLS_JUMP   = 5;

    localparam int TNEW_LOAD  = 2;
    localparam int TNEW_ALU   = 1;
    localparam int TNEW_NONE  = 0;

    localparam int TUSE_EARLY = 0;
    localparam int TUSE_ALU   = 1;
    localparam int TUSE_STORE = 2;

    localparam logic [4:0] REG_RA = 5'd31;

    typedef enum logic [4:0] {
        K_ILLEGAL, K_ADDU, K_SUBU, K_SLT, K_SLL, K_JR,
        K_LW, K_LB, K_SW, K_SB, K_BEQ, K_BNE,
        K_LUI, K_ORI, K_ADDIU, K_CMCO, K_J, K_JAL
    } instr_kind_e;

endpackage

// File: rtl/instr_decode.sv
// Combinational decoder: classifies one instruction word and derives its destination,
// source usage, operand deadlines (T_use) and result latency (T_new).
module instr_decode
    import mips_defs::*;
#(
    parameter int EXT    = 0,
    parameter int TNEW_W = 2
) (
    input  logic [31:0]       i_instr,
    output logic [5:0]        o_cls,
    output logic [4:0]        o_dst,
    output logic              o_useRs,
    output logic              o_useRt,
    output logic [TNEW_W-1:0] o_tuseRs,
    output logic [TNEW_W-1:0] o_tuseRt,
    output logic [TNEW_W-1:0] o_tnew,
    output logic              o_illegal
);

    logic [5:0]  w_op;
    logic [5:0]  w_fn;
    instr_kind_e w_kind;

    assign w_op = i_instr[31:26];
    assign w_fn = i_instr[5:0];

    // Extension encodings stay illegal unless EXT is set.
    always_comb begin
        w_kind = K_ILLEGAL;
        case (w_op)
            OP_SPECIAL: begin
                case (w_fn)
                    FN_ADDU: w_kind = K_ADDU;
                    FN_SUBU: w_kind = K_SUBU;
                    FN_JR:   w_kind = K_JR;
                    FN_SLT:  if (EXT != 0) w_kind = K_SLT;
                    FN_SLL:  if (EXT != 0) w_kind = K_SLL;
                    default: w_kind = K_ILLEGAL;
                endcase
            end
            OP_LW:    w_kind = K_LW;
            OP_SW:    w_kind = K_SW;
            OP_BEQ:   w_kind = K_BEQ;
            OP_LUI:   w_kind = K_LUI;
            OP_ORI:   w_kind = K_ORI;
            OP_J:     w_kind = K_J;
            OP_JAL:   w_kind = K_JAL;
            OP_CMCO:  w_kind = K_CMCO;
            OP_ADDIU: if (EXT != 0) w_kind = K_ADDIU;
            OP_BNE:   if (EXT != 0) w_kind = K_BNE;
            OP_LB:    if (EXT != 0) w_kind = K_LB;
            OP_SB:    if (EXT != 0) w_kind = K_SB;
            default:  w_kind = K_ILLEGAL;
        endcase
    end

    always_comb begin
        o_cls     = '0;
        o_dst     = '0;
        o_useRs   = 1'b0;
        o_useRt   = 1'b0;
        o_tuseRs  = TNEW_W'(TUSE_ALU);
        o_tuseRt  = TNEW_W'(TUSE_ALU);
        o_tnew    = TNEW_W'(TNEW_NONE);
        o_illegal = 1'b0;
        case (w_kind)
            K_ADDU, K_SUBU, K_SLT: begin
                o_cls[CLS_ALU_R] = 1'b1;
                o_dst   = i_instr[15:11];
                o_useRs = 1'b1;
                o_useRt = 1'b1;
                o_tnew  = TNEW_W'(TNEW_ALU);
            end
            K_SLL: begin
                o_cls[CLS_ALU_R] = 1'b1;
                o_dst   = i_instr[15:11];
                o_useRt = 1'b1;
                o_tnew  = TNEW_W'(TNEW_ALU);
            end
            K_ORI, K_ADDIU: begin
                o_cls[CLS_ALU_I] = 1'b1;
                o_dst   = i_instr[20:16];
                o_useRs = 1'b1;
                o_tnew  = TNEW_W'(TNEW_ALU);
            end
            K_LUI, K_CMCO: begin
                o_cls[CLS_ALU_I] = 1'b1;
                o_dst   = i_instr[20:16];
                o_tnew  = TNEW_W'(TNEW_ALU);
            end
            K_LW, K_LB: begin
                o_cls[CLS_LOAD] = 1'b1;
                o_dst   = i_instr[20:16];
                o_useRs = 1'b1;
                o_tnew  = TNEW_W'(TNEW_LOAD);
            end
            K_SW, K_SB: begin
                o_cls[CLS_STORE] = 1'b1;
                o_useRs  = 1'b1;
                o_useRt  = 1'b1;
                o_tuseRt = TNEW_W'(TUSE_STORE);
            end
            K_BEQ, K_BNE: begin
                o_cls[CLS_BRANCH] = 1'b1;
                o_useRs  = 1'b1;
                o_useRt  = 1'b1;
                o_tuseRs = TNEW_W'(TUSE_EARLY);
                o_tuseRt = TNEW_W'(TUSE_EARLY);
            end
            K_JR: begin
                o_cls[CLS_JUMP] = 1'b1;
                o_useRs  = 1'b1;
                o_tuseRs = TNEW_W'(TUSE_EARLY);
            end
            K_J: o_cls[CLS_JUMP] = 1'b1;
            K_JAL: begin
                o_cls[CLS_JUMP] = 1'b1;
                o_dst = REG_RA;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_hazard_pipe.sv
// D-stage decode plus E/M/W tracking registers; raises stall when a D source
// would be needed before an older in-flight result is ready.
module decode_hazard_pipe
    import mips_defs::*;
#(
    parameter int EXT    = 0,
    parameter int TNEW_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr_d,
    input  logic              valid_d,
    output logic              stall,
    output logic [5:0]        cls_e,
    output logic [4:0]        dst_e,
    output logic [4:0]        dst_m,
    output logic [4:0]        dst_w,
    output logic [TNEW_W-1:0] tnew_e,
    output logic [TNEW_W-1:0] tnew_m,
    output logic              illegal_e
);

    logic [5:0]        w_cls;
    logic [4:0]        w_dst;
    logic              w_useRs;
    logic              w_useRt;
    logic [TNEW_W-1:0] w_tuseRs;
    logic [TNEW_W-1:0] w_tuseRt;
    logic [TNEW_W-1:0] w_tnew;
    logic              w_illegal;
    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic              w_rsHaz;
    logic              w_rtHaz;
    logic              w_issue;

    logic [5:0]        r_clsE;
    logic [4:0]        r_dstE;
    logic [TNEW_W-1:0] r_tnewE;
    logic              r_illegalE;
    logic [4:0]        r_dstM;
    logic [TNEW_W-1:0] r_tnewM;
    logic [4:0]        r_dstW;

    instr_decode #(
        .EXT    (EXT),
        .TNEW_W (TNEW_W)
    ) u_decode (
        .i_instr   (instr_d),
        .o_cls     (w_cls),
        .o_dst     (w_dst),
        .o_useRs   (w_useRs),
        .o_useRt   (w_useRt),
        .o_tuseRs  (w_tuseRs),
        .o_tuseRt  (w_tuseRt),
        .o_tnew    (w_tnew),
        .o_illegal (w_illegal)
    );

    assign w_rs = instr_d[25:21];
    assign w_rt = instr_d[20:16];

    // $0 is hard-wired, so a source of 0 never waits on anything.
    assign w_rsHaz = w_useRs && (w_rs != 5'd0) &&
                     (((w_rs == r_dstE) && (r_tnewE > w_tuseRs)) ||
                      ((w_rs == r_dstM) && (r_tnewM > w_tuseRs)));
    assign w_rtHaz = w_useRt && (w_rt != 5'd0) &&
                     (((w_rt == r_dstE) && (r_tnewE > w_tuseRt)) ||
                      ((w_rt == r_dstM) && (r_tnewM > w_tuseRt)));

    assign stall   = valid_d && (w_rsHaz || w_rtHaz);
    assign w_issue = valid_d && !stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clsE     <= '0;
            r_dstE     <= '0;
            r_tnewE    <= '0;
            r_illegalE <= 1'b0;
        end else if (w_issue) begin
            r_clsE     <= w_cls;
            r_dstE     <= w_dst;
            r_tnewE    <= w_tnew;
            r_illegalE <= w_illegal;
        end else begin
            r_clsE     <= '0;
            r_dstE     <= '0;
            r_tnewE    <= '0;
            r_illegalE <= 1'b0;
        end
    end

    // One cycle of latency has elapsed by the time a result reaches M.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dstM  <= '0;
            r_tnewM <= '0;
            r_dstW  <= '0;
        end else begin
            r_dstM  <= r_dstE;
            r_tnewM <= (r_tnewE != '0) ? (r_tnewE - TNEW_W'(1)) : '0;
            r_dstW  <= r_dstM;
        end
    end

    assign cls_e     = r_clsE;
    assign dst_e     = r_dstE;
    assign tnew_e    = r_tnewE;
    assign illegal_e = r_illegalE;
    assign dst_m     = r_dstM;
    assign tnew_m    = r_tnewM;
    assign dst_w     = r_dstW;

endmodule
